// File: rtl/cdb_pkg.sv
// Shared types and default widths for the common-data-bus arbiter slice.
// Optional build macro used by this slice: CDB_ARB_LSU_PRIORITY_EN.
package cdb_pkg;

    // Widths shared with the ROB and physical register file.
    localparam int ROB_SIZE_WIDTH         = 5;
    localparam int PHYSICAL_REG_NUM_WIDTH = 6;

    // Default CDB configuration: ALU0, ALU1, LSU (LSU is always the last index).
    localparam int CDB_NUM_SRC    = 3;
    localparam int CDB_DATA_W     = 32;
    localparam int CDB_FIFO_DEPTH = 2;

    // One completed result as buffered and broadcast.
    typedef struct packed {
        logic [ROB_SIZE_WIDTH-1:0]         tag;
        logic [PHYSICAL_REG_NUM_WIDTH-1:0] reg_dst;
        logic                              reg_wr;
        logic [CDB_DATA_W-1:0]             data;
    } cdb_entry_t;

    // Increment an index modulo n (n need not be a power of two).
    function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result-source and CDB broadcast bundle for cdb_arbiter.
// master = functional-unit side / bus consumers, slave = arbiter.
interface cdb_arbiter_if
    import cdb_pkg::*;
#(
    parameter int NUM_SRC   = CDB_NUM_SRC,
    parameter int ROB_TAG_W = ROB_SIZE_WIDTH,
    parameter int PREG_W    = PHYSICAL_REG_NUM_WIDTH,
    parameter int DATA_W    = CDB_DATA_W
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Per-source result push
    logic [NUM_SRC-1:0]           src_valid;
    logic [NUM_SRC-1:0]           src_ready;
    logic [NUM_SRC*ROB_TAG_W-1:0] src_tag;
    logic [NUM_SRC*PREG_W-1:0]    src_reg_dst;
    logic [NUM_SRC-1:0]           src_reg_wr;
    logic [NUM_SRC*DATA_W-1:0]    src_data;

    // Broadcast
    logic                 cdb_valid;
    logic [ROB_TAG_W-1:0] cdb_tag;
    logic [PREG_W-1:0]    cdb_reg_dst;
    logic                 cdb_reg_wr;
    logic [DATA_W-1:0]    cdb_data;
    logic [SRC_W-1:0]     cdb_src;

    modport master (
        output src_valid, src_tag, src_reg_dst, src_reg_wr, src_data,
        input  src_ready,
        input  cdb_valid, cdb_tag, cdb_reg_dst, cdb_reg_wr, cdb_data, cdb_src
    );

    modport slave (
        input  src_valid, src_tag, src_reg_dst, src_reg_wr, src_data,
        output src_ready,
        output cdb_valid, cdb_tag, cdb_reg_dst, cdb_reg_wr, cdb_data, cdb_src
    );

endinterface

// File: rtl/cdb_src_fifo.sv
// Small per-source skid FIFO of cdb_entry_t. Head is read combinationally so
// an entry pushed at one edge can be arbitrated at the very next edge.
module cdb_src_fifo
    import cdb_pkg::*;
#(
    parameter int DEPTH = CDB_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  logic       pop,
    input  cdb_entry_t din,
    output logic       full,
    output logic       empty,
    output cdb_entry_t head
);
    localparam int AW = $clog2(DEPTH);

    cdb_entry_t    mem_reg [DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW:0]   count_reg;
    logic          push_ok;
    logic          pop_ok;

    // Status comes from registered count only: a full FIFO refuses a push even if it pops.
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_reg[rd_ptr_reg];

    // Storage write; a write during flush/reset is harmless since wr_ptr does not advance.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers results from NUM_SRC functional units and
// broadcasts one per cycle, round-robin, on a registered CDB.
// Build macro CDB_ARB_LSU_PRIORITY_EN: the LSU (last source) wins whenever it
// has a result; the other sources round-robin among themselves.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_SRC    = CDB_NUM_SRC,
    parameter int ROB_TAG_W  = ROB_SIZE_WIDTH,
    parameter int PREG_W     = PHYSICAL_REG_NUM_WIDTH,
    parameter int DATA_W     = CDB_DATA_W,
    parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
`ifdef CDB_ARB_LSU_PRIORITY_EN
    localparam int RR_N = NUM_SRC - 1;
`else
    localparam int RR_N = NUM_SRC;
`endif

    cdb_entry_t         src_entry [NUM_SRC];
    cdb_entry_t         head      [NUM_SRC];
    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] pop;

    logic               lsu_win;
    logic               grant_valid;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   rr_next;

    logic [SRC_W-1:0]   rr_ptr_reg;
    logic               cdb_valid_reg;
    logic [SRC_W-1:0]   cdb_src_reg;
    cdb_entry_t         cdb_entry_reg;

    assign bus.src_ready = ~full;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_entry[gi] = '{
                tag:     bus.src_tag[gi*ROB_TAG_W +: ROB_TAG_W],
                reg_dst: bus.src_reg_dst[gi*PREG_W +: PREG_W],
                reg_wr:  bus.src_reg_wr[gi],
                data:    bus.src_data[gi*DATA_W +: DATA_W]
            };
            assign pop[gi] = grant_valid && (grant_idx == SRC_W'(gi));

            cdb_src_fifo #(
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk   (clk),
                .reset (reset),
                .flush (flush),
                .push  (bus.src_valid[gi]),
                .pop   (pop[gi]),
                .din   (src_entry[gi]),
                .full  (full[gi]),
                .empty (empty[gi]),
                .head  (head[gi])
            );
        end
    endgenerate

`ifdef CDB_ARB_LSU_PRIORITY_EN
    assign lsu_win = !empty[NUM_SRC-1] && !flush;
`else
    assign lsu_win = 1'b0;
`endif

    // Pick the winner: LSU override (if built in), else first non-empty head from rr_ptr upward.
    always_comb begin
        int               idx;
        logic [SRC_W-1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        cand        = '0;
        if (lsu_win) begin
            grant_valid = 1'b1;
            grant_idx   = SRC_W'(NUM_SRC - 1);
        end else begin
            for (int k = 0; k < RR_N; k++) begin
                idx = int'(rr_ptr_reg) + k;
                if (idx >= RR_N) begin
                    idx = idx - RR_N;
                end
                cand = SRC_W'(idx);
                if (!grant_valid && !empty[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
        // A flush cycle neither broadcasts nor moves the pointer.
        if (flush) begin
            grant_valid = 1'b0;
        end
        rr_next = SRC_W'(wrap_inc(32'(grant_idx), RR_N));
    end

    // Registered CDB broadcast and round-robin pointer update.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_reg    <= '0;
            cdb_valid_reg <= 1'b0;
            cdb_src_reg   <= '0;
            cdb_entry_reg <= '0;
        end else begin
            cdb_valid_reg <= grant_valid;
            if (grant_valid) begin
                cdb_entry_reg <= head[grant_idx];
                cdb_src_reg   <= grant_idx;
                if (!lsu_win) begin
                    rr_ptr_reg <= rr_next;
                end
            end
        end
    end

    assign bus.cdb_valid   = cdb_valid_reg;
    assign bus.cdb_tag     = cdb_entry_reg.tag;
    assign bus.cdb_reg_dst = cdb_entry_reg.reg_dst;
    assign bus.cdb_reg_wr  = cdb_entry_reg.reg_wr;
    assign bus.cdb_data    = cdb_entry_reg.data;
    assign bus.cdb_src     = cdb_src_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for cdb_arbiter (3 sources, depth-2 FIFOs).
// The vector table follows the CDB_ARB_LSU_PRIORITY_EN build setting.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    cdb_arbiter_if bus ();

    cdb_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       fl;
        logic [2:0] vld;
        logic [4:0] t0;
        logic [4:0] t1;
        logic [4:0] t2;
        logic       ev;
        logic [4:0] et;
        logic [1:0] es;
        logic [2:0] er;
    } vec_t;

    vec_t vecs[$];
    int   vec_cnt  = 0;
    int   miscompares = 0;

    // Payload encoding used by the table: derived from the tag, zero for tag 0.
    function automatic logic [5:0] enc_dst(logic [4:0] t);
        return {t, 1'b0};
    endfunction

    function automatic logic [31:0] enc_data(logic [4:0] t);
        return {3'b000, t, 3'b000, t, 3'b000, t, 3'b000, t};
    endfunction

    function automatic vec_t mk(logic rst, logic fl, logic [2:0] vld,
                                logic [4:0] t0, logic [4:0] t1, logic [4:0] t2,
                                logic ev, logic [4:0] et, logic [1:0] es, logic [2:0] er);
        vec_t v;
        v.rst = rst; v.fl = fl; v.vld = vld;
        v.t0 = t0; v.t1 = t1; v.t2 = t2;
        v.ev = ev; v.et = et; v.es = es; v.er = er;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset           = v.rst;
        flush           = v.fl;
        bus.src_valid   = v.vld;
        bus.src_tag     = {v.t2, v.t1, v.t0};
        bus.src_reg_dst = {enc_dst(v.t2), enc_dst(v.t1), enc_dst(v.t0)};
        bus.src_data    = {enc_data(v.t2), enc_data(v.t1), enc_data(v.t0)};
        bus.src_reg_wr  = {v.t2[0], v.t1[0], v.t0[0]};
    endtask

    task automatic check(input string name, input logic ev, input logic [4:0] et,
                         input logic [5:0] edst, input logic [31:0] edata,
                         input logic ewr, input logic [1:0] es, input logic [2:0] er);
        vec_cnt++;
        $display("%s: valid=%0d tag=%0d dst=%0d data=%h wr=%0d src=%0d ready=%b", name,
                 bus.cdb_valid, bus.cdb_tag, bus.cdb_reg_dst, bus.cdb_data,
                 bus.cdb_reg_wr, bus.cdb_src, bus.src_ready);
        if (bus.cdb_valid !== ev) begin
            miscompares++;
            $display("FAIL %s cdb_valid got %0d want %0d", name, bus.cdb_valid, ev);
        end
        if (bus.cdb_tag !== et) begin
            miscompares++;
            $display("FAIL %s cdb_tag got %0d want %0d", name, bus.cdb_tag, et);
        end
        if (bus.cdb_reg_dst !== edst) begin
            miscompares++;
            $display("FAIL %s cdb_reg_dst got %0d want %0d", name, bus.cdb_reg_dst, edst);
        end
        if (bus.cdb_data !== edata) begin
            miscompares++;
            $display("FAIL %s cdb_data got %h want %h", name, bus.cdb_data, edata);
        end
        if (bus.cdb_reg_wr !== ewr) begin
            miscompares++;
            $display("FAIL %s cdb_reg_wr got %0d want %0d", name, bus.cdb_reg_wr, ewr);
        end
        if (bus.cdb_src !== es) begin
            miscompares++;
            $display("FAIL %s cdb_src got %0d want %0d", name, bus.cdb_src, es);
        end
        if (bus.src_ready !== er) begin
            miscompares++;
            $display("FAIL %s src_ready got %b want %b", name, bus.src_ready, er);
        end
    endtask

    // Watchdog: the run is a fixed number of edges, so this only trips on a hang.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t idle;
        idle = mk(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 3'b111);

`ifdef CDB_ARB_LSU_PRIORITY_EN
        // LSU priority: LSU drains first, then ALUs round-robin
        vecs.push_back(mk(1, 0, 3'b000,  0,  0,  0, 0,  0, 0, 3'b111));
        vecs.push_back(mk(0, 0, 3'b101, 10,  0,  1, 0,  0, 0, 3'b111));
        vecs.push_back(mk(0, 0, 3'b101, 11,  0,  2, 1,  1, 2, 3'b110));
        vecs.push_back(mk(0, 0, 3'b001, 12,  0,  0, 1,  2, 2, 3'b110));
        vecs.push_back(mk(0, 0, 3'b001, 12,  0,  0, 1, 10, 0, 3'b111));
        vecs.push_back(mk(0, 0, 3'b001, 12,  0,  0, 1, 11, 0, 3'b111));
        vecs.push_back(mk(0, 0, 3'b110,  0,  5,  6, 1, 12, 0, 3'b111));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 1,  6, 2, 3'b111));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 1,  5, 1, 3'b111));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 0,  5, 1, 3'b111));
`else
        // Contention: all sources push tags 0..8
        vecs.push_back(mk(1, 0, 3'b000,  0,  0,  0, 0,  0, 0, 3'b111));
        vecs.push_back(mk(0, 0, 3'b111,  0,  1,  2, 0,  0, 0, 3'b111));
        vecs.push_back(mk(0, 0, 3'b111,  3,  4,  5, 1,  0, 0, 3'b001));
        vecs.push_back(mk(0, 0, 3'b111,  6,  7,  8, 1,  1, 1, 3'b010));
        vecs.push_back(mk(0, 0, 3'b110,  0,  7,  8, 1,  2, 2, 3'b100));
        vecs.push_back(mk(0, 0, 3'b100,  0,  0,  8, 1,  3, 0, 3'b001));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 1,  4, 1, 3'b011));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 1,  5, 2, 3'b111));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 1,  6, 0, 3'b111));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 1,  7, 1, 3'b111));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 1,  8, 2, 3'b111));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 0,  8, 2, 3'b111));
        // Flush with buffered entries and a concurrent push; rr_ptr must survive
        vecs.push_back(mk(0, 0, 3'b111, 10, 11, 12, 0,  8, 2, 3'b111));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 1, 10, 0, 3'b111));
        vecs.push_back(mk(0, 1, 3'b001, 13,  0,  0, 0, 10, 0, 3'b111));
        vecs.push_back(mk(0, 0, 3'b101, 14,  0, 15, 0, 10, 0, 3'b111));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 1, 15, 2, 3'b111));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 1, 14, 0, 3'b111));
        // Full source 1 refuses a push in the cycle it pops
        vecs.push_back(mk(0, 0, 3'b101, 20,  0, 22, 0, 14, 0, 3'b111));
        vecs.push_back(mk(0, 0, 3'b111, 23, 21, 24, 1, 22, 2, 3'b110));
        vecs.push_back(mk(0, 0, 3'b010,  0, 25,  0, 1, 20, 0, 3'b101));
        vecs.push_back(mk(0, 0, 3'b010,  0, 26,  0, 1, 21, 1, 3'b111));
        vecs.push_back(mk(0, 0, 3'b010,  0, 26,  0, 1, 24, 2, 3'b101));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 1, 23, 0, 3'b101));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 1, 25, 1, 3'b111));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 1, 26, 1, 3'b111));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 0, 26, 1, 3'b111));
        // Reset mid-stream while broadcasting
        vecs.push_back(mk(0, 0, 3'b011, 30, 31,  0, 0, 26, 1, 3'b111));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 1, 30, 0, 3'b111));
        vecs.push_back(mk(1, 0, 3'b000,  0,  0,  0, 0,  0, 0, 3'b111));
        vecs.push_back(mk(0, 0, 3'b100,  0,  0,  3, 0,  0, 0, 3'b111));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 1,  3, 2, 3'b111));
        vecs.push_back(mk(0, 0, 3'b011,  4,  5,  0, 0,  3, 2, 3'b111));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 1,  4, 0, 3'b111));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 1,  5, 1, 3'b111));
        vecs.push_back(mk(0, 0, 3'b000,  0,  0,  0, 0,  5, 1, 3'b111));
`endif

        // Reset state
        drive(idle);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset", 1'b0, 5'd0, 6'd0, 32'd0, 1'b0, 2'd0, 3'b111);

        // Single source: ALU0 result with explicit payload, two-edge latency
        drive(idle);
        bus.src_valid   = 3'b001;
        bus.src_tag     = {5'd0, 5'd0, 5'd3};
        bus.src_reg_dst = {6'd0, 6'd0, 6'd12};
        bus.src_data    = {32'd0, 32'd0, 32'hDEADBEEF};
        bus.src_reg_wr  = 3'b001;
        @(posedge clk); #1;
        check("single_accept", 1'b0, 5'd0, 6'd0, 32'd0, 1'b0, 2'd0, 3'b111);
        drive(idle);
        @(posedge clk); #1;
        check("single_bcast", 1'b1, 5'd3, 6'd12, 32'hDEADBEEF, 1'b1, 2'd0, 3'b111);
        @(posedge clk); #1;
        check("single_hold", 1'b0, 5'd3, 6'd12, 32'hDEADBEEF, 1'b1, 2'd0, 3'b111);

        // Table
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].et, enc_dst(vecs[i].et),
                  enc_data(vecs[i].et), vecs[i].et[0], vecs[i].es, vecs[i].er);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Sits directly downstream of the functional-unit wrapper (ALUs and load/store unit).
- Each FU result source pushes completed results (ROB tag, physical destination, data) into a small per-source skid FIFO.
- A round-robin arbiter selects one result per cycle and drives it, registered, onto the single common data bus (CDB) consumed by the reservation stations, register file and ROB.
- A flush input discards all buffered results on mispredict/exception recovery.

Parameters:
- NUM_SRC, 3, number of result sources (ALU0, ALU1, LSU); index NUM_SRC-1 is always the LSU.
- ROB_TAG_W, 5, ROB tag width (matches ROB_SIZE_WIDTH).
- PREG_W, 6, physical register index width (matches PHYSICAL_REG_NUM_WIDTH).
- DATA_W, 32, result data width.
- FIFO_DEPTH, 2, entries per source buffer; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all buffered and in-flight results.
- src_valid  in  NUM_SRC  per-source result valid.
- src_ready  out  NUM_SRC  per-source buffer not full.
- src_tag  in  NUM_SRC*ROB_TAG_W  packed ROB tags; source i occupies bits [i*ROB_TAG_W +: ROB_TAG_W].
- src_reg_dst  in  NUM_SRC*PREG_W  packed physical destination registers.
- src_reg_wr  in  NUM_SRC  result writes a register (0 for stores and branches).
- src_data  in  NUM_SRC*DATA_W  packed result data.
- cdb_valid  out  1  broadcast valid.
- cdb_tag  out  ROB_TAG_W  broadcast ROB tag.
- cdb_reg_dst  out  PREG_W  broadcast destination register.
- cdb_reg_wr  out  1  broadcast register-write flag.
- cdb_data  out  DATA_W  broadcast data.
- cdb_src  out  $clog2(NUM_SRC)  winning source index (debug/trace).

Behaviour:
- Reset (synchronous, highest priority):
  - All FIFOs empty; round-robin pointer = 0.
  - cdb_valid, cdb_tag, cdb_reg_dst, cdb_reg_wr, cdb_data and cdb_src are all 0.
  - src_ready = all ones from the first cycle after reset.
- Push:
  - src_ready[i] = (count[i] != FIFO_DEPTH), computed from registered count only.
  - A push occurs when src_valid[i] && src_ready[i].
  - A full FIFO that pops in the same cycle still refuses the push; no ready-through-pop.
- Arbitration:
  - Candidates are the non-empty FIFO heads.
  - The winner is the first candidate found searching from rr_ptr upward, wrapping modulo NUM_SRC.
  - After a grant, rr_ptr = winner+1, wrapping to 0 after NUM_SRC-1. rr_ptr is unchanged when there is no grant.
- Output:
  - Winner's head is popped and its fields are loaded into the output registers with cdb_valid=1.
  - With no candidate, cdb_valid=0 and the payload registers hold their last value.
  - The CDB has no backpressure; a broadcast lasts exactly one cycle.
- Latency:
  - A result accepted at edge t can appear on the CDB no earlier than the cycle after edge t+1.
  - It is not bypassed into the same-edge arbitration.
- Simultaneous push and pop on the same FIFO (not full): count unchanged, order preserved.
- Ordering: results from the same source are broadcast in acceptance order. There is no ordering guarantee across sources.
- Wrap-around: FIFO read/write pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is log2(FIFO_DEPTH)+1 bits.
- Flush:
  - At an edge with flush=1, all FIFOs empty and cdb_valid=0 in the following cycle.
  - Pushes presented in the flush cycle are dropped.
  - rr_ptr is unchanged.
- Reset mid-operation: identical to a flush, plus rr_ptr = 0 and payload registers = 0.
- Fairness: with all sources continuously non-empty, each source wins exactly once every NUM_SRC cycles.

Optional Feature:
- Macro: CDB_ARB_LSU_PRIORITY_EN.
- When defined:
  - The LSU source (index NUM_SRC-1) wins whenever its FIFO is non-empty.
  - The remaining sources round-robin among themselves.
  - rr_ptr advances only on a non-LSU grant.
- When undefined: pure round-robin over all sources as above.
- Port list is identical in both builds.

Decomposition:
- Shared package (cdb_pkg):
  - typedef cdb_entry_t, a packed struct {tag, reg_dst, reg_wr, data}.
  - Constants for the default widths, sourced from the existing ROB_SIZE_WIDTH and PHYSICAL_REG_NUM_WIDTH definitions.
- Sub-module: one natural sub-module, cdb_src_fifo, a parameterised FIFO of cdb_entry_t with push, pop, flush, full, empty and head. It is instantiated NUM_SRC times via generate.
- The arbiter logic stays in the top module.

Test Plan:
1. Single source: ALU0 pushes tag=3, dst=12, data=0xDEADBEEF at edge 1 -> one-cycle cdb_valid after edge 2 carrying those values with cdb_src=0; cdb_valid=0 the next cycle.
2. Contention: all three sources push every cycle, tags 0..8 -> CDB order is sources 0,1,2,0,1,2; src_ready drops to 0 on every source once its count reaches 2; no tag is lost or duplicated.
3. Full-with-pop: source 1 full with ALU0 and LSU also non-empty, src_valid[1]=1 held -> push refused while count=2; the push is accepted the cycle after source 1 is granted.
4. Flush: entries buffered in all FIFOs, flush=1 for one cycle together with a new push -> cdb_valid=0 next cycle, all src_ready=1, the pushed entry is never broadcast.
5. Reset mid-stream: reset asserted while cdb_valid=1 -> all CDB outputs 0 next cycle; a subsequent single push from source 2 wins with cdb_src=2 even though rr_ptr=0.
6. With CDB_ARB_LSU_PRIORITY_EN defined: LSU and ALU0 both continuously valid -> the LSU wins every cycle until its FIFO empties; ALU0 is then granted.
